// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode skid buffer: two-entry queue of fetched words,
// decoded to a one-hot instruction vector at enqueue time.
module fetch_decode_buffer #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 im_valid,
    input  logic [31:0]          im_inst,
    input  logic [31:0]          im_pc,
    output logic                 im_ready,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 id_valid,
    output logic [31:0]          id_inst,
    output logic [31:0]          id_pc,
    output logic [31:0]          i,
    output logic [ILL_CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] dec;
    } entry_t;

    logic [1:0] count;
    entry_t     head;
    entry_t     skid;
    entry_t     in_e;
    logic       accept;
    logic       consume;

    function automatic logic [31:0] decode(input logic [31:0] w);
        logic [31:0] d;
        logic [5:0]  op;
        logic [5:0]  fn;
        d  = '0;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00) begin
            unique case (fn)
                6'h20:   d[0]  = 1'b1;
                6'h21:   d[1]  = 1'b1;
                6'h22:   d[2]  = 1'b1;
                6'h23:   d[3]  = 1'b1;
                6'h24:   d[4]  = 1'b1;
                6'h25:   d[5]  = 1'b1;
                6'h26:   d[6]  = 1'b1;
                6'h27:   d[7]  = 1'b1;
                6'h2A:   d[8]  = 1'b1;
                6'h2B:   d[9]  = 1'b1;
                6'h00:   d[10] = 1'b1;
                6'h02:   d[11] = 1'b1;
                6'h03:   d[12] = 1'b1;
                6'h04:   d[13] = 1'b1;
                6'h06:   d[14] = 1'b1;
                6'h07:   d[15] = 1'b1;
                6'h08:   d[16] = 1'b1;
                default: d[31] = 1'b1;
            endcase
        end else begin
            unique case (op)
                6'h08:   d[17] = 1'b1;
                6'h09:   d[18] = 1'b1;
                6'h0C:   d[19] = 1'b1;
                6'h0D:   d[20] = 1'b1;
                6'h0E:   d[21] = 1'b1;
                6'h23:   d[22] = 1'b1;
                6'h2B:   d[23] = 1'b1;
                6'h04:   d[24] = 1'b1;
                6'h05:   d[25] = 1'b1;
                6'h0A:   d[26] = 1'b1;
                6'h0B:   d[27] = 1'b1;
                6'h0F:   d[28] = 1'b1;
                6'h02:   d[29] = 1'b1;
                6'h03:   d[30] = 1'b1;
                default: d[31] = 1'b1;
            endcase
        end
        return d;
    endfunction

    assign in_e     = '{inst: im_inst, pc: im_pc, dec: decode(im_inst)};
    assign im_ready = (count < 2'd2);
    assign id_valid = (count != 2'd0);
    assign accept   = im_valid & im_ready;
    assign consume  = id_valid & ~stall;
    assign id_inst  = head.inst;
    assign id_pc    = head.pc;
    assign i        = id_valid ? head.dec : 32'd0;

    // Queue occupancy and head/skid movement; flush empties everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (accept) begin
                        head  <= in_e;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && consume) begin
                        head <= in_e;
                    end else if (accept) begin
                        skid  <= in_e;
                        count <= 2'd2;
                    end else if (consume) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (consume) begin
                        head  <= skid;
                        count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    // Saturating count of illegal words actually handed to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (!flush && consume && head.dec[31] &&
                     illegal_cnt != {ILL_CNT_W{1'b1}}) begin
            illegal_cnt <= illegal_cnt + ILL_CNT_W'(1);
        end
    end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Upstream neighbour of the single-cycle control unit.
- Accepts fetched instruction words and their PCs from the fetch side using a valid/ready handshake, and holds them in a 2-entry buffer.
- Decodes each word at enqueue into the 32-bit one-hot instruction vector i[31:0] that the control unit consumes.
- Presents the buffer head with a registered one-hot vector, and supports stall, flush and illegal-instruction accounting.

Parameters:
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- im_valid  input  1  fetch side offers im_inst/im_pc this cycle.
- im_inst  input  32  fetched instruction word.
- im_pc  input  32  PC of im_inst.
- im_ready  output  1  buffer can accept a word this cycle.
- stall  input  1  consumer holds the current head.
- flush  input  1  discard all buffered and in-flight words (branch/jump redirect).
- id_valid  output  1  head entry valid.
- id_inst  output  32  head instruction word.
- id_pc  output  32  head PC.
- i  output  32  one-hot decode of the head; i[31] marks an illegal instruction.
- illegal_cnt  output  ILL_CNT_W  count of consumed illegal instructions, saturating.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Entry count = 0.
  - id_valid, id_inst, id_pc, i and illegal_cnt = 0.
  - im_ready = 1 after reset release.
- Transfer rules:
  - accept = im_valid & im_ready.
  - consume = id_valid & ~stall.
  - im_ready = (count < 2), driven from registered state only. There is no combinational path from stall or flush to im_ready.
- Buffer (head register plus one skid entry), all under no flush:
  - count 0, accept: word becomes head next cycle; latency 1 cycle.
  - count 1, accept & consume: new word becomes head; count stays 1.
  - count 1, accept, no consume: word goes to skid; count becomes 2.
  - count 1 or 2, consume, no accept: skid (if any) moves to head; count decrements.
  - count 2: im_ready = 0, so no accept is possible.
- Flush:
  - Synchronous; count becomes 0 next cycle.
  - Any word accepted in the flush cycle is dropped. im_ready still follows count, so fetch sees the word as taken.
  - flush takes priority over stall and accept.
  - A head discarded by flush does not update illegal_cnt.
- Empty buffer: id_valid = 0 and i = 0. All-zero i makes the control unit drive RF_W = 1, so the integrating level must qualify RF_W, DM_w and the PC-select terms with id_valid.
- Decode: combinational on im_inst at enqueue; the result is stored alongside the entry. op = inst[31:26], funct = inst[5:0].
  - R-type (op 0x00), by funct:
    - 0x20 add → i[0]; 0x21 addu → i[1]; 0x22 sub → i[2]; 0x23 subu → i[3].
    - 0x24 and → i[4]; 0x25 or → i[5]; 0x26 xor → i[6]; 0x27 nor → i[7].
    - 0x2A slt → i[8]; 0x2B sltu → i[9].
    - 0x00 sll → i[10]; 0x02 srl → i[11]; 0x03 sra → i[12].
    - 0x04 sllv → i[13]; 0x06 srlv → i[14]; 0x07 srav → i[15].
    - 0x08 jr → i[16].
  - Other opcodes, by op:
    - 0x08 addi → i[17]; 0x09 addiu → i[18].
    - 0x0C andi → i[19]; 0x0D ori → i[20]; 0x0E xori → i[21].
    - 0x23 lw → i[22]; 0x2B sw → i[23].
    - 0x04 beq → i[24]; 0x05 bne → i[25].
    - 0x0A slti → i[26]; 0x0B sltiu → i[27]; 0x0F lui → i[28].
    - 0x02 j → i[29]; 0x03 jal → i[30].
  - Anything else → i[31] only.
  - Exactly one bit of i is set whenever id_valid = 1. Word 0x00000000 decodes as sll (i[10]).
- illegal_cnt:
  - Increments when consume & i[31].
  - Holds at 2^ILL_CNT_W-1.
  - Not cleared by flush; cleared only by rst_n.
- Reset mid-operation: all state, including buffered entries, clears immediately.

Test Plan:
- Single word, no stall: 0x012A4020 (add $8,$9,$10), pc 0x00400000 offered with im_valid=1 → next cycle id_valid=1, id_pc=0x00400000, i=0x00000001; im_ready stays 1.
- Back-pressure: hold stall=1 and offer 3 consecutive words (sw 0xAD090004, beq 0x1109FFFF, jal 0x0C100000) → im_ready drops after 2 accepts, and the third word is held by fetch. Head shows i=0x00800000 (sw) until stall=0, then i=0x01000000 (beq), then i=0x40000000 (jal); order is preserved and nothing is lost.
- Flush with full buffer plus a simultaneous offer → next cycle id_valid=0, i=0, count=0; the offered word never appears at the head.
- Illegal op 0xFC000000 consumed 3 times → i=0x80000000 each time; illegal_cnt=3. With ILL_CNT_W=2 and 5 illegal words → saturates at 3.
- Count 1 with simultaneous accept and consume, over 10 cycles of streaming → one word per cycle, id_valid stays 1, count never exceeds 1.
- rst_n asserted low mid-stream with 2 entries buffered → id_valid, i and illegal_cnt read 0 immediately (asynchronous); im_ready=1 after release.
